control_fsm: RTL and testbench

- Multi-cycle Moore controller that sequences the TinyV datapath through fetch, register read, decode, execute, memory and writeback.
- Drives every datapath select and enable from the 6-bit codop returned by the datapath.
- Adds run/halt gating, illegal-opcode trap and a retired-instruction counter.
- Drives irWrCtl and pcCondEn. The datapath gates IR load with irWrCtl, and gates its ALU==1 PC-write term with pcCondEn.

---
 rtl/control_fsm.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle Moore controller for the TinyV datapath.
// Sequences fetch, register read, decode, execute, memory and writeback,
// with run/halt gating, an illegal-opcode trap and a retired-instruction count.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   run        in   start/continue, sampled only at instruction boundaries
//   codop      in   opcode returned by the datapath
//   pcWrSel    out  PC source: 0 ALU, 1 D reg, 2 jump target
//   pcCtrl     out  unconditional PC write
//   pcCondEn   out  branch PC write enable (qualified by ALU==1 in datapath)
//   irWrCtl    out  IR load enable
//   memAdrSel  out  memory address: 0 PC, 1 D reg
//   memWrCtl   out  memory write
//   aluOp      out  ALU function
//   aluASel    out  ALU A: 0 PC, 1 A reg
//   aluBSel    out  ALU B: 0 B reg, 1 const 4, 2 sign-extended imm
//   regWCtl    out  register-file write
//   regDataSel out  register write data: 0 DM, 1 D reg
//   regWSel    out  register write index: 0 ir[21:17], 1 ir[26:22], 2 r31
//   busy       out  executing an instruction (not IDLE/HALT/TRAP)
//   halted     out  in HALT
//   trap       out  in TRAP
//   instret    out  retired-instruction count
module control_fsm #(
    parameter int unsigned OPCODE_WIDTH = 6,
    parameter int unsigned ALU_SEL_SIZE = 4,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter logic [ALU_SEL_SIZE-1:0] ALU_ADD   = ALU_SEL_SIZE'(4'h0),
    parameter logic [ALU_SEL_SIZE-1:0] ALU_PASSA = ALU_SEL_SIZE'(4'hE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] codop,
    output logic [1:0]              pcWrSel,
    output logic                    pcCtrl,
    output logic                    pcCondEn,
    output logic                    irWrCtl,
    output logic                    memAdrSel,
    output logic                    memWrCtl,
    output logic [ALU_SEL_SIZE-1:0] aluOp,
    output logic                    aluASel,
    output logic [1:0]              aluBSel,
    output logic                    regWCtl,
    output logic                    regDataSel,
    output logic [1:0]              regWSel,
    output logic                    busy,
    output logic                    halted,
    output logic                    trap,
    output logic [CNT_WIDTH-1:0]    instret
);

    localparam logic [ALU_SEL_SIZE-1:0] ALU_BR0 = ALU_SEL_SIZE'(4'h8);
    localparam logic [ALU_SEL_SIZE-1:0] ALU_BR1 = ALU_SEL_SIZE'(4'h9);

    localparam logic [1:0] CLS_R   = 2'b00;
    localparam logic [1:0] CLS_I   = 2'b01;
    localparam logic [1:0] CLS_SPC = 2'b10;

    localparam logic [3:0] FN_LW   = 4'h0;
    localparam logic [3:0] FN_SW   = 4'h1;
    localparam logic [3:0] FN_BR0  = 4'h2;
    localparam logic [3:0] FN_BR1  = 4'h3;
    localparam logic [3:0] FN_JMP  = 4'h4;
    localparam logic [3:0] FN_JAL  = 4'h5;
    localparam logic [3:0] FN_HALT = 4'hF;

    typedef enum logic [4:0] {
        S_IDLE,
        S_FETCH,
        S_REGRD,
        S_DECODE,
        S_EX_R,
        S_WB_R,
        S_EX_I,
        S_WB_I,
        S_ADDR,
        S_MEMRD,
        S_WB_LD,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_JAL1,
        S_JAL2,
        S_HALT,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic [1:0]              pc_wr_sel;
        logic                    pc_ctrl;
        logic                    pc_cond_en;
        logic                    ir_wr_ctl;
        logic                    mem_adr_sel;
        logic                    mem_wr_ctl;
        logic [ALU_SEL_SIZE-1:0] alu_op;
        logic                    alu_a_sel;
        logic [1:0]              alu_b_sel;
        logic                    reg_w_ctl;
        logic                    reg_data_sel;
        logic [1:0]              reg_w_sel;
        logic                    busy;
        logic                    halted;
        logic                    trap;
    } ctrl_t;

    state_t               r_state;
    state_t               w_next_state;
    ctrl_t                r_ctrl;
    ctrl_t                w_ctrl;
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_instret;
    logic [1:0]           w_cls;
    logic [3:0]           w_fn;

    assign w_cls = codop[5:4];
    assign w_fn  = codop[3:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, retire strobe, and control word for the state being entered.
    // Decoding the next state lets the control word be registered while still
    // lining up exactly with the state it belongs to.
    always_comb begin
        w_next_state = r_state;
        w_retire     = 1'b0;
        w_ctrl       = '0;

        case (r_state)
            S_IDLE:   if (run) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_REGRD;
            S_REGRD:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_cls)
                    CLS_R:   w_next_state = S_EX_R;
                    CLS_I:   w_next_state = S_EX_I;
                    CLS_SPC: begin
                        case (w_fn)
                            FN_LW, FN_SW:   w_next_state = S_ADDR;
                            FN_BR0, FN_BR1: w_next_state = S_BRANCH;
                            FN_JMP:         w_next_state = S_JUMP;
                            FN_JAL:         w_next_state = S_JAL1;
                            FN_HALT: begin
                                w_next_state = S_HALT;
                                w_retire     = 1'b1;
                            end
                            default:        w_next_state = S_TRAP;
                        endcase
                    end
                    default: w_next_state = S_TRAP;
                endcase
            end
            S_EX_R:   w_next_state = S_WB_R;
            S_EX_I:   w_next_state = S_WB_I;
            S_ADDR:   w_next_state = (w_fn == FN_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next_state = S_WB_LD;
            S_JAL1:   w_next_state = S_JAL2;
            // Instruction completion: run is only looked at here.
            S_WB_R, S_WB_I, S_WB_LD, S_MEMWR, S_BRANCH, S_JUMP, S_JAL2: begin
                w_retire     = 1'b1;
                w_next_state = run ? S_FETCH : S_IDLE;
            end
            S_HALT:   w_next_state = S_HALT;
            S_TRAP:   w_next_state = S_TRAP;
            default:  w_next_state = S_IDLE;
        endcase

        case (w_next_state)
            S_FETCH: begin
                w_ctrl.ir_wr_ctl = 1'b1;
                w_ctrl.alu_b_sel = 2'd1;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.pc_ctrl   = 1'b1;
                w_ctrl.busy      = 1'b1;
            end
            // D captures PC+imm here so it already holds the branch target.
            S_REGRD, S_DECODE: begin
                w_ctrl.alu_b_sel = 2'd2;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.busy      = 1'b1;
            end
            S_EX_R: begin
                w_ctrl.alu_a_sel = 1'b1;
                w_ctrl.alu_b_sel = 2'd0;
                w_ctrl.alu_op    = ALU_SEL_SIZE'(w_fn);
                w_ctrl.busy      = 1'b1;
            end
            S_WB_R: begin
                w_ctrl.reg_data_sel = 1'b1;
                w_ctrl.reg_w_sel    = 2'd0;
                w_ctrl.reg_w_ctl    = 1'b1;
                w_ctrl.busy         = 1'b1;
            end
            S_EX_I: begin
                w_ctrl.alu_a_sel = 1'b1;
                w_ctrl.alu_b_sel = 2'd2;
                w_ctrl.alu_op    = ALU_SEL_SIZE'(w_fn);
                w_ctrl.busy      = 1'b1;
            end
            S_WB_I: begin
                w_ctrl.reg_data_sel = 1'b1;
                w_ctrl.reg_w_sel    = 2'd1;
                w_ctrl.reg_w_ctl    = 1'b1;
                w_ctrl.busy         = 1'b1;
            end
            S_ADDR: begin
                w_ctrl.alu_a_sel = 1'b1;
                w_ctrl.alu_b_sel = 2'd2;
                w_ctrl.alu_op    = ALU_ADD;
                w_ctrl.busy      = 1'b1;
            end
            // Address ALU controls held so D stays stable during the access.
            S_MEMRD: begin
                w_ctrl.alu_a_sel   = 1'b1;
                w_ctrl.alu_b_sel   = 2'd2;
                w_ctrl.alu_op      = ALU_ADD;
                w_ctrl.mem_adr_sel = 1'b1;
                w_ctrl.busy        = 1'b1;
            end
            S_WB_LD: begin
                w_ctrl.reg_data_sel = 1'b0;
                w_ctrl.reg_w_sel    = 2'd1;
                w_ctrl.reg_w_ctl    = 1'b1;
                w_ctrl.busy         = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.alu_a_sel   = 1'b1;
                w_ctrl.alu_b_sel   = 2'd2;
                w_ctrl.alu_op      = ALU_ADD;
                w_ctrl.mem_adr_sel = 1'b1;
                w_ctrl.mem_wr_ctl  = 1'b1;
                w_ctrl.busy        = 1'b1;
            end
            // Compare A/B; the datapath writes PC<=D only when the result is 1.
            S_BRANCH: begin
                w_ctrl.alu_a_sel  = 1'b1;
                w_ctrl.alu_b_sel  = 2'd0;
                w_ctrl.alu_op     = w_fn[0] ? ALU_BR1 : ALU_BR0;
                w_ctrl.pc_wr_sel  = 2'd1;
                w_ctrl.pc_cond_en = 1'b1;
                w_ctrl.busy       = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.alu_a_sel = 1'b0;
                w_ctrl.pc_wr_sel = 2'd2;
                w_ctrl.pc_ctrl   = 1'b1;
                w_ctrl.busy      = 1'b1;
            end
            // Pass PC through so D captures the return address.
            S_JAL1: begin
                w_ctrl.alu_a_sel = 1'b0;
                w_ctrl.alu_op    = ALU_PASSA;
                w_ctrl.busy      = 1'b1;
            end
            S_JAL2: begin
                w_ctrl.reg_data_sel = 1'b1;
                w_ctrl.reg_w_sel    = 2'd2;
                w_ctrl.reg_w_ctl    = 1'b1;
                w_ctrl.pc_wr_sel    = 2'd2;
                w_ctrl.pc_ctrl      = 1'b1;
                w_ctrl.busy         = 1'b1;
            end
            S_HALT:  w_ctrl.halted = 1'b1;
            S_TRAP:  w_ctrl.trap   = 1'b1;
            default: w_ctrl = '0;
        endcase
    end

    // Registered control word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= '0;
        end else begin
            r_ctrl <= w_ctrl;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_WIDTH'(1);
        end
    end

    assign pcWrSel    = r_ctrl.pc_wr_sel;
    assign pcCtrl     = r_ctrl.pc_ctrl;
    assign pcCondEn   = r_ctrl.pc_cond_en;
    assign irWrCtl    = r_ctrl.ir_wr_ctl;
    assign memAdrSel  = r_ctrl.mem_adr_sel;
    assign memWrCtl   = r_ctrl.mem_wr_ctl;
    assign aluOp      = r_ctrl.alu_op;
    assign aluASel    = r_ctrl.alu_a_sel;
    assign aluBSel    = r_ctrl.alu_b_sel;
    assign regWCtl    = r_ctrl.reg_w_ctl;
    assign regDataSel = r_ctrl.reg_data_sel;
    assign regWSel    = r_ctrl.reg_w_sel;
    assign busy       = r_ctrl.busy;
    assign halted     = r_ctrl.halted;
    assign trap       = r_ctrl.trap;
    assign instret    = r_instret;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: expected per-cycle control words and
// instret values are queued as each instruction is issued and compared one
// per clock as the DUT steps through its states.
module tb_control_fsm;

    logic        clk;
    logic        reset;
    logic        run;
    logic [5:0]  codop;
    logic [1:0]  pcWrSel;
    logic        pcCtrl;
    logic        pcCondEn;
    logic        irWrCtl;
    logic        memAdrSel;
    logic        memWrCtl;
    logic [3:0]  aluOp;
    logic        aluASel;
    logic [1:0]  aluBSel;
    logic        regWCtl;
    logic        regDataSel;
    logic [1:0]  regWSel;
    logic        busy;
    logic        halted;
    logic        trap;
    logic [31:0] instret;

    control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .codop      (codop),
        .pcWrSel    (pcWrSel),
        .pcCtrl     (pcCtrl),
        .pcCondEn   (pcCondEn),
        .irWrCtl    (irWrCtl),
        .memAdrSel  (memAdrSel),
        .memWrCtl   (memWrCtl),
        .aluOp      (aluOp),
        .aluASel    (aluASel),
        .aluBSel    (aluBSel),
        .regWCtl    (regWCtl),
        .regDataSel (regDataSel),
        .regWSel    (regWSel),
        .busy       (busy),
        .halted     (halted),
        .trap       (trap),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] pws;
        logic       pcc;
        logic       pce;
        logic       irw;
        logic       mas;
        logic       mwc;
        logic [3:0] aop;
        logic       aas;
        logic [1:0] abs;
        logic       rwc;
        logic       rds;
        logic [1:0] rws;
        logic       bsy;
        logic       hlt;
        logic       trp;
    } ctl_t;

    typedef enum int {
        X_IDLE, X_FETCH, X_REGRD, X_DECODE, X_EX_R, X_WB_R, X_EX_I, X_WB_I,
        X_ADDR, X_MEMRD, X_WB_LD, X_MEMWR, X_BRANCH, X_JUMP, X_JAL1, X_JAL2,
        X_HALT, X_TRAP
    } xst_t;

    typedef struct {
        string       tag;
        ctl_t        ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_instret;
    int          n_chk;
    int          n_err;
    ctl_t        w_obs;

    assign w_obs = '{pws: pcWrSel, pcc: pcCtrl, pce: pcCondEn, irw: irWrCtl,
                     mas: memAdrSel, mwc: memWrCtl, aop: aluOp, aas: aluASel,
                     abs: aluBSel, rwc: regWCtl, rds: regDataSel, rws: regWSel,
                     bsy: busy, hlt: halted, trp: trap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word per state, written straight from the state table.
    function automatic ctl_t exp_ctl(input xst_t s, input logic [3:0] f);
        ctl_t c;
        c = '0;
        c.bsy = 1'b1;
        case (s)
            X_IDLE:   c.bsy = 1'b0;
            X_FETCH:  begin c.irw = 1'b1; c.abs = 2'd1; c.pcc = 1'b1; end
            X_REGRD,
            X_DECODE: c.abs = 2'd2;
            X_EX_R:   begin c.aas = 1'b1; c.aop = f; end
            X_WB_R:   begin c.rds = 1'b1; c.rwc = 1'b1; end
            X_EX_I:   begin c.aas = 1'b1; c.abs = 2'd2; c.aop = f; end
            X_WB_I:   begin c.rds = 1'b1; c.rws = 2'd1; c.rwc = 1'b1; end
            X_ADDR:   begin c.aas = 1'b1; c.abs = 2'd2; end
            X_MEMRD:  begin c.aas = 1'b1; c.abs = 2'd2; c.mas = 1'b1; end
            X_WB_LD:  begin c.rws = 2'd1; c.rwc = 1'b1; end
            X_MEMWR:  begin c.aas = 1'b1; c.abs = 2'd2; c.mas = 1'b1; c.mwc = 1'b1; end
            X_BRANCH: begin c.aas = 1'b1; c.aop = f; c.pws = 2'd1; c.pce = 1'b1; end
            X_JUMP:   begin c.pws = 2'd2; c.pcc = 1'b1; end
            X_JAL1:   c.aop = 4'hE;
            X_JAL2:   begin c.rds = 1'b1; c.rws = 2'd2; c.rwc = 1'b1; c.pws = 2'd2; c.pcc = 1'b1; end
            X_HALT:   begin c.bsy = 1'b0; c.hlt = 1'b1; end
            X_TRAP:   begin c.bsy = 1'b0; c.trp = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input xst_t s, input logic [3:0] f);
        exp_t e;
        e.tag = s.name();
        e.ctl = exp_ctl(s, f);
        e.cnt = m_instret;
        q.push_back(e);
    endtask

    // Advance one clock and compare the oldest expectation.
    task automatic step();
        exp_t e;
        e = q.pop_front();
        @(posedge clk);
        #1;
        check({e.tag, ".ctl"}, 32'(w_obs), 32'(e.ctl));
        check({e.tag, ".instret"}, instret, e.cnt);
        check({e.tag, ".inv_wr"}, 32'(regWCtl & memWrCtl), 32'd0);
        check({e.tag, ".inv_pc"}, 32'(pcCtrl & pcCondEn), 32'd0);
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    // Issue one instruction with run held high and queue its full state walk.
    task automatic issue(input logic [5:0] op);
        codop = op;
        push(X_FETCH, 4'h0);
        push(X_REGRD, 4'h0);
        push(X_DECODE, 4'h0);
        case (op[5:4])
            2'b00: begin push(X_EX_R, op[3:0]); push(X_WB_R, 4'h0); m_instret++; end
            2'b01: begin push(X_EX_I, op[3:0]); push(X_WB_I, 4'h0); m_instret++; end
            2'b10: begin
                case (op[3:0])
                    4'h0: begin push(X_ADDR, 4'h0); push(X_MEMRD, 4'h0); push(X_WB_LD, 4'h0); m_instret++; end
                    4'h1: begin push(X_ADDR, 4'h0); push(X_MEMWR, 4'h0); m_instret++; end
                    4'h2: begin push(X_BRANCH, 4'h8); m_instret++; end
                    4'h3: begin push(X_BRANCH, 4'h9); m_instret++; end
                    4'h4: begin push(X_JUMP, 4'h0); m_instret++; end
                    4'h5: begin push(X_JAL1, 4'h0); push(X_JAL2, 4'h0); m_instret++; end
                    4'hF: begin m_instret++; push(X_HALT, 4'h0); end
                    default: push(X_TRAP, 4'h0);
                endcase
            end
            default: push(X_TRAP, 4'h0);
        endcase
        drain();
    endtask

    // Reset with run toggling, then release with run high.
    task automatic do_reset(input int cycles);
        reset = 1'b0;
        m_instret = 32'd0;
        for (int i = 0; i < cycles; i++) begin
            run = i[0];
            push(X_IDLE, 4'h0);
            step();
        end
        reset = 1'b1;
        run   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        m_instret = 32'd0;
        reset     = 1'b0;
        run       = 1'b0;
        codop     = 6'h00;

        do_reset(4);

        issue(6'h00);
        issue(6'h20);
        issue(6'h21);
        issue(6'h22);
        issue(6'h23);
        issue(6'h24);
        issue(6'h25);
        issue(6'h05);
        issue(6'h1A);

        // Drop run during EX_I: finish the instruction, then idle.
        codop = 6'h10;
        push(X_FETCH, 4'h0);
        push(X_REGRD, 4'h0);
        push(X_DECODE, 4'h0);
        push(X_EX_I, 4'h0);
        drain();
        run = 1'b0;
        push(X_WB_I, 4'h0);
        m_instret++;
        push(X_IDLE, 4'h0);
        push(X_IDLE, 4'h0);
        drain();
        run = 1'b1;
        issue(6'h03);

        // A run glitch inside an instruction is ignored.
        codop = 6'h07;
        push(X_FETCH, 4'h0);
        drain();
        run = 1'b0;
        push(X_REGRD, 4'h0);
        push(X_DECODE, 4'h0);
        push(X_EX_R, 4'h7);
        drain();
        run = 1'b1;
        push(X_WB_R, 4'h0);
        m_instret++;
        drain();
        issue(6'h11);

        // Reset in the middle of EX_R: immediate return to IDLE, no write.
        codop = 6'h01;
        push(X_FETCH, 4'h0);
        push(X_REGRD, 4'h0);
        push(X_DECODE, 4'h0);
        push(X_EX_R, 4'h1);
        drain();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.ctl", 32'(w_obs), 32'(exp_ctl(X_IDLE, 4'h0)));
        check("async_rst.instret", instret, 32'd0);
        check("async_rst.regWCtl", 32'(regWCtl), 32'd0);
        do_reset(2);

        // HALT retires once and then ignores run.
        issue(6'h00);
        issue(6'h2F);
        run = 1'b0;
        push(X_HALT, 4'h0);
        push(X_HALT, 4'h0);
        drain();
        run = 1'b1;
        push(X_HALT, 4'h0);
        push(X_HALT, 4'h0);
        drain();

        // Illegal class-11 opcode traps without retiring.
        do_reset(2);
        issue(6'h3A);
        push(X_TRAP, 4'h0);
        push(X_TRAP, 4'h0);
        drain();

        // Unused class-10 encoding also traps.
        do_reset(2);
        issue(6'h24);
        issue(6'h2B);
        run = 1'b0;
        push(X_TRAP, 4'h0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
